// File: rtl/hall_pattern_generator_if.sv
// Hall emulator control/status bundle: rate and direction in, Hall pattern and position out.
interface hall_pattern_generator_if;
  localparam int unsigned PER_W = 16;
  localparam int unsigned POS_W = 8;
  localparam int unsigned H_W   = 3;

  logic             EN;
  logic             DIR;
  logic [PER_W-1:0] PERIOD;
  logic [H_W-1:0]   H;
  logic             STEP;
  logic [POS_W-1:0] POS;
  logic             REV_TICK;

  modport master (output EN, DIR, PERIOD, input H, STEP, POS, REV_TICK);
  modport slave  (input EN, DIR, PERIOD, output H, STEP, POS, REV_TICK);
endinterface

// File: rtl/hall_pattern_generator.sv
// Emulated 3-phase Hall sensor: steps a 6-state Gray-like sequence at a programmable
// rate and tracks mechanical position within one revolution.
module hall_pattern_generator #(
  parameter int unsigned TICKS_PER_REV = 24
) (
  input logic                     CLK,
  input logic                     RST,
  hall_pattern_generator_if.slave bus
);
  localparam int unsigned IDX_W = 3;
  localparam int unsigned PER_W = 16;
  localparam int unsigned POS_W = 8;
  localparam int unsigned H_W   = 3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(5);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(TICKS_PER_REV - 1);
  localparam logic [H_W-1:0]   H_RESET  = 3'b101;

  // Sequence index to Hall pattern; adjacent entries differ in exactly one bit.
  function automatic logic [H_W-1:0] idx_to_h(input logic [IDX_W-1:0] idx);
    logic [H_W-1:0] h;
    case (idx)
      3'd0:    h = 3'b101;
      3'd1:    h = 3'b100;
      3'd2:    h = 3'b110;
      3'd3:    h = 3'b010;
      3'd4:    h = 3'b011;
      3'd5:    h = 3'b001;
      default: h = H_RESET;
    endcase
    return h;
  endfunction

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_sh_q, per_sh_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [H_W-1:0]   h_q, h_d;
  logic             step_q, step_d;
  logic             rev_tick_q, rev_tick_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      per_sh_q   <= '0;
      pos_q      <= '0;
      h_q        <= H_RESET;
      step_q     <= 1'b0;
      rev_tick_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      per_sh_q   <= per_sh_d;
      pos_q      <= pos_d;
      h_q        <= h_d;
      step_q     <= step_d;
      rev_tick_q <= rev_tick_d;
    end
  end

  // Rate counter; PERIOD is only sampled into the shadow when idle or on a step edge.
  always_comb begin
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    per_sh_d   = per_sh_q;
    pos_d      = pos_q;
    step_d     = 1'b0;
    rev_tick_d = 1'b0;

    if (!bus.EN || (per_sh_q == '0)) begin
      cnt_d    = '0;
      per_sh_d = bus.PERIOD;
    end else if (cnt_q != (per_sh_q - PER_W'(1))) begin
      cnt_d = cnt_q + PER_W'(1);
    end else begin
      step_d   = 1'b1;
      cnt_d    = '0;
      per_sh_d = bus.PERIOD;
      if (bus.DIR) begin
        idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        rev_tick_d = (pos_q == POS_LAST);
        pos_d      = rev_tick_d ? '0 : pos_q + POS_W'(1);
      end else begin
        idx_d      = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
        rev_tick_d = (pos_q == '0);
        pos_d      = rev_tick_d ? POS_LAST : pos_q - POS_W'(1);
      end
    end

    h_d = idx_to_h(idx_d);
  end

  assign bus.H        = h_q;
  assign bus.STEP     = step_q;
  assign bus.POS      = pos_q;
  assign bus.REV_TICK = rev_tick_q;
endmodule
